// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake plus serial line outputs of the FIFO-fed UART transmitter.
// The master modport is the transmitter; the slave modport is the FIFO/line side.
interface fifo_uart_tx_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             i_empty;
    logic [WIDTH-1:0] i_r_data;
    logic             o_r_inc;
    logic             o_tx;
    logic             o_busy;

    modport master (
        input  i_empty,
        input  i_r_data,
        output o_r_inc,
        output o_tx,
        output o_busy
    );

    modport slave (
        output i_empty,
        output i_r_data,
        input  o_r_inc,
        input  o_tx,
        input  o_busy
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a first-word-fall-through FIFO and
// serialises them as start, LSB-first data, optional parity and stop bits.
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PAR_EN       = 1'b0,
    parameter bit          PAR_ODD      = 1'b0
) (
    input logic            i_r_clk,
    input logic            i_r_rstn,
    fifo_uart_tx_if.master bus
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  timer_q, timer_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_nxt;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             pop;
    logic             bit_end;

    // Reset is folded into the pop so no word is consumed while held in reset.
    assign pop       = (state_q == StIdle) & ~bus.i_empty & i_r_rstn;
    assign bit_end   = (timer_q == CntLast);
    assign shift_nxt = shift_q >> 1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        if (state_q != StIdle) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end
        // tx_d always carries the level of the state being entered next cycle.
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = bus.i_r_data;
                    par_d   = (^bus.i_r_data) ^ PAR_ODD;
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == IdxLast) begin
                        idx_d = '0;
                        if (PAR_EN) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_r_clk) begin
        if (!i_r_rstn) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.o_r_inc = pop;
    assign bus.o_tx    = tx_q;
    assign bus.o_busy  = (state_q != StIdle);
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, equal to the FIFO read data width.
REQ-002 Parameter CLKS_PER_BIT, default 16: i_r_clk cycles per serial bit; legal values are 2 or greater.
REQ-003 Parameter PAR_EN, default 0: 1 inserts one parity bit after the data bits.
REQ-004 Parameter PAR_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PAR_EN=0.
REQ-005 i_r_clk  input  1  Sole clock, the FIFO read-domain clock; all state changes on its rising edge.
REQ-006 i_r_rstn  input  1  Reset, synchronous and active-low, sampled on the i_r_clk rising edge.
REQ-007 i_empty  input  1  FIFO empty flag; the FIFO holds no word while this is 1.
REQ-008 i_r_data  input  WIDTH  FIFO head word, valid whenever i_empty=0 (first-word-fall-through read).
REQ-009 o_r_inc  output  1  FIFO pop strobe, one cycle per consumed word.
REQ-010 o_tx  output  1  Serial line, idle high.
REQ-011 o_busy  output  1  1 while a frame is in progress (all states except IDLE).

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, encoded in registers.
REQ-013 o_r_inc SHALL be combinational and equal (state==IDLE) AND (i_empty==0) AND (i_r_rstn==1).
REQ-014 o_r_inc SHALL never be 1 when i_empty=1 and never be 1 in two consecutive cycles.
REQ-015 On every edge where o_r_inc=1, the block SHALL load i_r_data into an internal shift register, compute parity over that word, clear the bit timer and enter START.
REQ-016 o_tx SHALL be registered; it SHALL be 0 for CLKS_PER_BIT cycles in START, beginning the cycle after the pop edge.
REQ-017 DATA SHALL drive WIDTH bits LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-018 The bit index SHALL advance only when the bit timer reaches CLKS_PER_BIT-1, and the timer SHALL wrap to 0 at that point.
REQ-019 After the last data bit the FSM SHALL enter PARITY when PAR_EN=1, otherwise STOP.
REQ-020 The PARITY bit SHALL be the XOR of the data bits when PAR_ODD=0, or its inverse when PAR_ODD=1, held for CLKS_PER_BIT cycles.
REQ-021 STOP SHALL drive o_tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-022 Frame length SHALL be (1+WIDTH+PAR_EN+1)*CLKS_PER_BIT cycles.
REQ-023 IDLE SHALL last at least one cycle, so back-to-back frames repeat every frame length + 1 cycles, with o_tx=1 throughout that IDLE cycle.
REQ-024 Changes on i_empty or i_r_data outside IDLE SHALL have no effect on the frame in progress.
REQ-025 In IDLE with i_empty=1, the block SHALL hold o_tx=1, o_busy=0 and o_r_inc=0 indefinitely.

Reset
REQ-026 When i_r_rstn=0 at an edge, the next cycle SHALL show state IDLE, o_tx=1, o_busy=0, and the bit timer, bit index and shift register cleared to 0.
REQ-027 o_r_inc SHALL be 0 during any cycle in which i_r_rstn=0.
REQ-028 A reset mid-frame SHALL abort the frame immediately (o_tx=1 the next cycle); the already-popped word is discarded and not retransmitted.
REQ-029 After reset release, the first pop SHALL occur in the first cycle with i_r_rstn=1 and i_empty=0.

Verification (WIDTH=8, CLKS_PER_BIT=4 unless stated)
REQ-030 Reset check: hold i_r_rstn=0 with i_empty=0 -> o_r_inc=0, o_tx=1 and o_busy=0 throughout.
REQ-031 Single word: PAR_EN=0, present 0xA5, i_empty falls at cycle T -> o_r_inc=1 only at T; o_tx from T+1 is 0 x4, then 1,0,1,0,0,1,0,1 (x4 each), then 1 x4; o_busy=0 again at T+41.
REQ-032 Parity: PAR_EN=1, PAR_ODD=0, data 0xA5 -> parity bit 0; data 0x07 -> parity bit 1; with PAR_ODD=1 both values invert; frame length is 44 cycles.
REQ-033 Back-to-back: three words 0x01, 0x80, 0xFF queued, PAR_EN=0 -> exactly 3 o_r_inc pulses 41 cycles apart; the bytes are received in order by a reference UART receiver.
REQ-034 Mid-frame reset: assert i_r_rstn=0 for 1 cycle during data bit 3 -> o_tx=1 the next cycle; if i_empty=0, the next frame starts with a fresh pop and the aborted word is not resent.
REQ-035 Empty toggling: pulse i_empty 1->0->1 during DATA -> no extra o_r_inc; the frame completes unchanged; with CLKS_PER_BIT=2 the bit timing remains exact.
